fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, meaning data bits per frame and width of fifo_data.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit, legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset, asynchronous, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit, meaning that the block may start new frames.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit, meaning the upstream FIFO empty flag.
REQ-007 The block SHALL have port fifo_data, input, DWIDTH bits, meaning the upstream FIFO registered read data, valid the cycle after fifo_rd_en.
REQ-008 The block SHALL have port fifo_rd_en, output, 1 bit, meaning a one-cycle FIFO pop request.
REQ-009 The block SHALL have port tx, output, 1 bit, meaning the serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit, meaning that the state is not IDLE.
REQ-011 The block SHALL have port tx_done, output, 1 bit, meaning a one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-013 In IDLE, when enable=1 and fifo_empty=0, the next state SHALL be FETCH; otherwise the state stays IDLE.
REQ-014 fifo_rd_en SHALL be 1 exactly while in FETCH, which lasts one cycle, then the state moves to LOAD.
REQ-015 LOAD SHALL last one cycle, capture fifo_data into the shift register, and move to START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive the shift register LSB first, holding each bit for CLKS_PER_BIT cycles, for DWIDTH bits.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, with tx_done=1 on its final cycle.
REQ-019 At the end of STOP, the next state SHALL be FETCH if enable=1 and fifo_empty=0, else IDLE; the inter-frame gap between back-to-back frames is exactly 2 cycles of tx=1.
REQ-020 tx SHALL be registered: it changes on the edge entering START, on each bit boundary, and on the edge entering STOP.
REQ-021 The frame SHALL be exactly (DWIDTH+2)*CLKS_PER_BIT cycles, measured from the tx falling edge to the end of STOP.
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, wrap to 0 on each bit boundary, and reset to 0 on entering START.
REQ-023 The bit counter SHALL be $clog2(DWIDTH)+1 bits wide and count 0..DWIDTH-1 within DATA.
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; it only prevents the next FETCH.
REQ-025 fifo_empty is sampled only in IDLE and at the end of STOP; changes at any other time SHALL be ignored.
REQ-026 fifo_rd_en SHALL never assert while fifo_empty=1 is sampled, and at most once per frame.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 On rst=1, asynchronously: state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, and all counters and the shift register =0.
REQ-029 Reset mid-frame SHALL abandon the byte without re-fetch; tx SHALL return high within the reset assertion.
REQ-030 After rst deasserts, the first FETCH SHALL occur no earlier than the first clk edge at which IDLE sees enable=1 and fifo_empty=0.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state typedef (3-bit encoding) and the localparams START_BIT=0 and STOP_BIT=1.
REQ-032 The sub-module uart_baud_tick (parameter CLKS_PER_BIT; inputs clk, rst and clear; output tick) SHALL generate bit-boundary ticks.
REQ-033 The expected implementation size SHALL be 150-250 lines of RTL.

Verification (DWIDTH=8, CLKS_PER_BIT=4)
REQ-034 Single byte: FIFO holds 0xA5 and enable=1 -> one fifo_rd_en pulse; tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; tx_done pulses once at cycle 40 of the frame.
REQ-035 Back-to-back: FIFO holds 0x01 and 0xFF -> two frames separated by exactly 2 idle-high cycles; exactly two fifo_rd_en pulses; busy stays 1 throughout.
REQ-036 Empty FIFO: fifo_empty=1 and enable=1 for 100 cycles -> fifo_rd_en=0, tx=1 and busy=0 throughout.
REQ-037 Enable drop: enable=0 at bit 3 of the 0x3C frame, with FIFO non-empty -> the frame completes intact, then IDLE with no further fifo_rd_en.
REQ-038 Reset mid-frame: rst pulsed during DATA bit 5 -> tx=1, busy=0 and tx_done=0 immediately; after release with the FIFO holding 0x5A, the next frame transmits 0x5A correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state encoding
// and the serial line levels for the start and stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every frame starts on a full bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = !clear && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO and sends 8N1-style
// frames (start, DWIDTH data bits LSB first, one stop bit) with a registered tx.
//
// state | meaning
// IDLE  | line high, waiting for enable and a non-empty FIFO
// FETCH | one-cycle FIFO pop request
// LOAD  | FIFO read data valid, captured into the shift register
// START | start bit on the line
// DATA  | data bits on the line, LSB first
// STOP  | stop bit; tx_done on its final cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BW = $clog2(DWIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

    tx_state_t         state, state_nxt;
    logic [DWIDTH-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              tick;
    logic              baud_clear;
    logic              can_start;

    assign can_start  = enable && !fifo_empty;
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        tx_done    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (can_start) state_nxt = FETCH;
            FETCH: begin
                fifo_rd_en = 1'b1;
                state_nxt  = LOAD;
            end
            LOAD:  state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && (bit_cnt == LAST_BIT)) state_nxt = STOP;
            STOP: begin
                if (tick) begin
                    tx_done   = 1'b1;
                    state_nxt = can_start ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The shift register is pre-shifted as each bit goes out, so tx always
    // reloads from bit 0 at the next boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx      <= STOP_BIT;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shreg   <= fifo_data;
                    bit_cnt <= '0;
                    tx      <= START_BIT;
                end
                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx      <= STOP_BIT;
                            bit_cnt <= '0;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: tx <= STOP_BIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx (DWIDTH=8, CLKS_PER_BIT=4) with a
// behavioural FIFO, a byte scoreboard and a table of expected line patterns.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int FRAME_CYC = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;

    fifo_uart_tx #(
        .DWIDTH       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Expected line pattern per byte, one entry per bit period, start bit at index 0.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    int         checks = 0;
    int         passes = 0;
    int         rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Advance one clock; models the FIFO's registered read port.
    task automatic step();
        logic rd;
        rd = fifo_rd_en;
        if (rd) begin
            rd_cnt++;
            chk("rd_while_empty", {31'd0, fifo_q.size() == 0}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic check_frame(input int idx, input int max_wait, input int drop_k, input int abort_k);
        int         n;
        logic [7:0] sb;
        logic [7:0] dec;
        n   = 0;
        dec = '0;
        while (tx !== 1'b0 && n < max_wait) begin
            step();
            n++;
        end
        chk("frame_start", {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        sb = exp_q.pop_front();
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k == drop_k) enable = 1'b0;
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk("abort_lines", {29'd0, tx, busy, tx_done}, 32'b100);
                return;
            end
            chk("frame_tx", {31'd0, tx}, {31'd0, tbl[idx].frame[k / CPB]});
            chk("frame_done_busy", {30'd0, tx_done, busy}, {30'd0, k == FRAME_CYC - 1, 1'b1});
            if (k >= CPB && k < FRAME_CYC - CPB && (k % CPB) == 1)
                dec[(k - CPB) / CPB] = tx;
            if (k < FRAME_CYC - 1) step();
        end
        chk("frame_byte", {24'd0, dec}, {24'd0, sb});
    endtask

    initial begin
        int rd0;
        tbl[0] = '{8'hA5, 10'b1101001010};
        tbl[1] = '{8'h01, 10'b1000000010};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'h3C, 10'b1001111000};
        tbl[4] = '{8'hC3, 10'b1110000110};
        tbl[5] = '{8'h5A, 10'b1010110100};

        rst        = 1'b1;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        @(negedge clk);
        chk("reset_outputs", {28'd0, tx, busy, fifo_rd_en, tx_done}, 32'b1000);
        step();
        rst = 1'b0;

        // Empty FIFO with enable high: nothing may happen.
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("empty_idle", {29'd0, fifo_rd_en, tx, busy}, 32'b010);
        end

        // Single byte.
        rd0 = rd_cnt;
        push(8'hA5);
        check_frame(0, 10, -1, -1);
        step();
        chk("single_idle_after", {31'd0, busy}, 32'd0);
        chk("single_rd_count", rd_cnt - rd0, 32'd1);

        // Back-to-back frames with a two-cycle high gap.
        rd0 = rd_cnt;
        push(8'h01);
        push(8'hFF);
        check_frame(1, 10, -1, -1);
        step();
        chk("gap1", {30'd0, tx, busy}, 32'b11);
        step();
        chk("gap2", {30'd0, tx, busy}, 32'b11);
        step();
        check_frame(2, 0, -1, -1);
        chk("b2b_rd_count", rd_cnt - rd0, 32'd2);

        // Enable dropped during data bit 3; FIFO stays non-empty.
        step();
        enable = 1'b1;
        rd0 = rd_cnt;
        push(8'h3C);
        push(8'h5A);
        check_frame(3, 10, CPB + 3 * CPB, -1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("drop_idle", {30'd0, fifo_rd_en, busy}, 32'd0);
        end
        chk("drop_rd_count", rd_cnt - rd0, 32'd1);
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;

        // Reset during data bit 5, then a clean frame afterwards.
        enable = 1'b1;
        rd0 = rd_cnt;
        push(8'hC3);
        check_frame(4, 10, -1, CPB + 5 * CPB + 1);
        push(8'h5A);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("in_reset", {29'd0, fifo_rd_en, tx, busy}, 32'b010);
        end
        rst = 1'b0;
        check_frame(5, 10, -1, -1);
        chk("reset_rd_count", rd_cnt - rd0, 32'd2);

        // Every table entry as a standalone frame.
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) step();
            push(tbl[i].data);
            check_frame(i, 10, -1, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule
